// File: rtl/scene_buffer_ctrl.sv
// scene_buffer_ctrl: double-buffered scene storage between the scene producer
// and the rasterizer. The producer fills the back buffer and commits it. On the
// next frame pulse the back buffer is copied to the front buffer, so the
// rasterizer only ever sees complete scenes.

package scene_buffer_pkg;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } vertex_2d_t;

  typedef struct packed {
    logic [2:0]  v0;
    logic [2:0]  v1;
    logic [2:0]  v2;
    logic [11:0] color;
  } triangle_t;

endpackage

module scene_buffer_ctrl
  import scene_buffer_pkg::*;
#(
  parameter int NUM_VERTS = 8,
  parameter int MAX_TRIS  = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_is_tri,
  input  logic [3:0] wr_index,
  input  vertex_2d_t wr_vertex,
  input  triangle_t  wr_tri,
  input  logic       commit,
  input  logic [3:0] commit_num_tris,
  output vertex_2d_t vertices_2d [NUM_VERTS],
  output triangle_t  triangles   [MAX_TRIS],
  output logic [3:0] num_triangles,
  output logic       swap_pulse,
  output logic [7:0] drop_count,
  output logic       err
);

  localparam int VIDX_W = $clog2(NUM_VERTS);
  localparam int TIDX_W = $clog2(MAX_TRIS);

  typedef enum logic {
    FILL,
    PENDING
  } state_t;

  state_t state;
  state_t state_next;

  vertex_2d_t back_verts [NUM_VERTS];
  triangle_t  back_tris  [MAX_TRIS];
  logic [3:0] back_count;

  logic [VIDX_W-1:0] vert_slot;
  logic [TIDX_W-1:0] tri_slot;
  logic              vert_in_range;
  logic              tri_in_range;
  logic              count_clamped;
  logic              accept;

  assign vert_slot     = wr_index[VIDX_W-1:0];
  assign tri_slot      = wr_index[TIDX_W-1:0];
  assign vert_in_range = int'(wr_index) < NUM_VERTS;
  assign tri_in_range  = int'(wr_index) < MAX_TRIS;
  assign count_clamped = int'(commit_num_tris) > MAX_TRIS;

  // Ready only while filling; held low during reset so no handshake completes.
  assign wr_ready = (state == FILL) && !rst;
  assign accept   = wr_valid && wr_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next-state logic: a commit parks the scene until the next frame pulse.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    unique case (state)
      FILL:    if (commit)  state_next = PENDING;
      PENDING: if (frame)   state_next = FILL;
      default:              state_next = FILL;
    endcase
  end

  // Back/front buffer storage, swap, drop counting and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both buffers are register arrays (not RAM) and must come up as
      // an all-zero scene, so every entry is cleared here on purpose.
      for (int i = 0; i < NUM_VERTS; i++) begin
        back_verts[i]  <= '0;
        vertices_2d[i] <= '0;
      end
      for (int i = 0; i < MAX_TRIS; i++) begin
        back_tris[i] <= '0;
        triangles[i] <= '0;
      end
      back_count    <= '0;
      num_triangles <= '0;
      swap_pulse    <= 1'b0;
      drop_count    <= '0;
      err           <= 1'b0;
    end else begin
      swap_pulse <= 1'b0;

      // Out-of-range writes still complete the handshake but are discarded.
      if (accept) begin
        if (wr_is_tri) begin
          if (tri_in_range) back_tris[tri_slot] <= wr_tri;
          else              err <= 1'b1;
        end else begin
          if (vert_in_range) back_verts[vert_slot] <= wr_vertex;
          else               err <= 1'b1;
        end
      end

      unique case (state)
        FILL: begin
          if (commit) begin
            if (count_clamped) begin
              back_count <= 4'(MAX_TRIS);
              err        <= 1'b1;
            end else begin
              back_count <= commit_num_tris;
            end
          end
          // A frame with nothing committed is a dropped frame, even when the
          // commit lands on the same edge.
          if (frame && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
        PENDING: begin
          if (frame) begin
            vertices_2d   <= back_verts;
            triangles     <= back_tris;
            num_triangles <= back_count;
            swap_pulse    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scene_buffer_ctrl.sv
// Directed self-checking bench for scene_buffer_ctrl.
module tb_scene_buffer_ctrl;
  import scene_buffer_pkg::*;

  localparam int NUM_VERTS = 8;
  localparam int MAX_TRIS  = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_is_tri;
  logic [3:0] wr_index;
  vertex_2d_t wr_vertex;
  triangle_t  wr_tri;
  logic       commit;
  logic [3:0] commit_num_tris;
  vertex_2d_t vertices_2d [NUM_VERTS];
  triangle_t  triangles   [MAX_TRIS];
  logic [3:0] num_triangles;
  logic       swap_pulse;
  logic [7:0] drop_count;
  logic       err;

  int checks   = 0;
  int failures = 0;

  scene_buffer_ctrl #(.NUM_VERTS(NUM_VERTS), .MAX_TRIS(MAX_TRIS)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame          (frame),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_is_tri      (wr_is_tri),
    .wr_index       (wr_index),
    .wr_vertex      (wr_vertex),
    .wr_tri         (wr_tri),
    .commit         (commit),
    .commit_num_tris(commit_num_tris),
    .vertices_2d    (vertices_2d),
    .triangles      (triangles),
    .num_triangles  (num_triangles),
    .swap_pulse     (swap_pulse),
    .drop_count     (drop_count),
    .err            (err)
  );

  always #5 clk = ~clk;

  function automatic vertex_2d_t mk_vert(input int xv, input int yv);
    vertex_2d_t v;
    v.x = 12'(xv);
    v.y = 12'(yv);
    return v;
  endfunction

  function automatic triangle_t mk_tri(input int a, input int b, input int c, input int col);
    triangle_t t;
    t.v0    = 3'(a);
    t.v1    = 3'(b);
    t.v2    = 3'(c);
    t.color = 12'(col);
    return t;
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vert(input int idx, input int xv, input int yv);
    wr_valid  = 1'b1;
    wr_is_tri = 1'b0;
    wr_index  = 4'(idx);
    wr_vertex = mk_vert(xv, yv);
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic write_tri(input int idx, input int a, input int b, input int c, input int col);
    wr_valid  = 1'b1;
    wr_is_tri = 1'b1;
    wr_index  = 4'(idx);
    wr_tri    = mk_tri(a, b, c, col);
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic do_commit(input int n);
    commit          = 1'b1;
    commit_num_tris = 4'(n);
    tick();
    commit          = 1'b0;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_wr_ready_low got=%b exp=0", wr_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wr_ready_high got=%b exp=1", wr_ready);
    end
    checks++;
    if (num_triangles !== 4'd0) begin
      failures++;
      $display("FAIL reset_num_tris got=%0d exp=0", num_triangles);
    end
    bad = 0;
    for (int i = 0; i < NUM_VERTS; i++) if (vertices_2d[i] !== '0) bad++;
    for (int i = 0; i < MAX_TRIS; i++)  if (triangles[i] !== '0)   bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_front_zero nonzero_entries=%0d exp=0", bad);
    end
    checks++;
    if (drop_count !== 8'd0 || err !== 1'b0 || swap_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got drop=%0d err=%b swap=%b exp drop=0 err=0 swap=0",
               drop_count, err, swap_pulse);
    end
  endtask

  task automatic test_swap();
    int bad;
    for (int i = 0; i < NUM_VERTS; i++) write_vert(i, 10 * i, 20 * i);
    write_tri(0, 0, 1, 2, 12'hF00);
    write_tri(1, 3, 4, 5, 12'h0F0);
    do_commit(2);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL swap_pending_ready got=%b exp=0", wr_ready);
    end
    // Writes offered while pending must be ignored.
    bad = 0;
    wr_valid  = 1'b1;
    wr_is_tri = 1'b0;
    wr_index  = 4'd0;
    wr_vertex = mk_vert(999, 999);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (wr_ready !== 1'b0) bad++;
    end
    wr_valid = 1'b0;
    checks++;
    if (bad != 0 || num_triangles !== 4'd0) begin
      failures++;
      $display("FAIL swap_hold_before_frame ready_high_cycles=%0d num_tris=%0d exp 0 and 0",
               bad, num_triangles);
    end
    frame_pulse();
    checks++;
    if (swap_pulse !== 1'b1 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL swap_pulse_ready got swap=%b ready=%b exp 1 1", swap_pulse, wr_ready);
    end
    checks++;
    if (num_triangles !== 4'd2) begin
      failures++;
      $display("FAIL swap_num_tris got=%0d exp=2", num_triangles);
    end
    for (int i = 0; i < NUM_VERTS; i++) begin
      checks++;
      if (vertices_2d[i] !== mk_vert(10 * i, 20 * i)) begin
        failures++;
        $display("FAIL swap_vert%0d got=%h exp=%h", i, vertices_2d[i], mk_vert(10 * i, 20 * i));
      end
    end
    checks++;
    if (triangles[0] !== mk_tri(0, 1, 2, 12'hF00) || triangles[1] !== mk_tri(3, 4, 5, 12'h0F0)
        || triangles[2] !== '0) begin
      failures++;
      $display("FAIL swap_tris got t0=%h t1=%h t2=%h", triangles[0], triangles[1], triangles[2]);
    end
    tick();
    checks++;
    if (swap_pulse !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL swap_pulse_one_cycle got swap=%b drop=%0d exp 0 0", swap_pulse, drop_count);
    end
  endtask

  task automatic test_drop();
    int swaps;
    swaps = 0;
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      if (swap_pulse !== 1'b0) swaps++;
      tick();
    end
    checks++;
    if (drop_count !== 8'd3) begin
      failures++;
      $display("FAIL drop_three got=%0d exp=3", drop_count);
    end
    checks++;
    if (swaps != 0 || num_triangles !== 4'd2 || vertices_2d[3] !== mk_vert(30, 60)) begin
      failures++;
      $display("FAIL drop_front_stable swaps=%0d num_tris=%0d v3=%h exp 0 2 %h",
               swaps, num_triangles, vertices_2d[3], mk_vert(30, 60));
    end
    for (int i = 0; i < 300; i++) begin
      frame_pulse();
      tick();
    end
    checks++;
    if (drop_count !== 8'd255) begin
      failures++;
      $display("FAIL drop_saturate got=%0d exp=255", drop_count);
    end
  endtask

  task automatic test_range();
    write_vert(9, 77, 77);
    checks++;
    if (err !== 1'b1 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL range_vert_err got err=%b ready=%b exp 1 1", err, wr_ready);
    end
    write_tri(11, 7, 6, 5, 12'hABC);
    do_commit(14);
    frame_pulse();
    checks++;
    if (num_triangles !== 4'd12) begin
      failures++;
      $display("FAIL range_clamp_count got=%0d exp=12", num_triangles);
    end
    checks++;
    if (vertices_2d[1] !== mk_vert(10, 20) || vertices_2d[7] !== mk_vert(70, 140)) begin
      failures++;
      $display("FAIL range_back_unchanged got v1=%h v7=%h exp %h %h",
               vertices_2d[1], vertices_2d[7], mk_vert(10, 20), mk_vert(70, 140));
    end
    checks++;
    if (triangles[11] !== mk_tri(7, 6, 5, 12'hABC) || triangles[1] !== mk_tri(3, 4, 5, 12'h0F0)) begin
      failures++;
      $display("FAIL range_tri_slots got t11=%h t1=%h exp %h %h", triangles[11], triangles[1],
               mk_tri(7, 6, 5, 12'hABC), mk_tri(3, 4, 5, 12'h0F0));
    end
  endtask

  task automatic test_commit_frame_same();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    // Write, commit (boundary count 12) and frame all on the same edge.
    wr_valid        = 1'b1;
    wr_is_tri       = 1'b0;
    wr_index        = 4'd0;
    wr_vertex       = mk_vert(5, 6);
    commit          = 1'b1;
    commit_num_tris = 4'd12;
    frame           = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    frame    = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || drop_count !== 8'd1 || swap_pulse !== 1'b0 || num_triangles !== 4'd0) begin
      failures++;
      $display("FAIL same_edge_no_swap got ready=%b drop=%0d swap=%b num=%0d exp 0 1 0 0",
               wr_ready, drop_count, swap_pulse, num_triangles);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_no_clamp_err got=%b exp=0", err);
    end
    tick();
    frame_pulse();
    checks++;
    if (swap_pulse !== 1'b1 || num_triangles !== 4'd12 || vertices_2d[0] !== mk_vert(5, 6)
        || drop_count !== 8'd1) begin
      failures++;
      $display("FAIL same_edge_next_swap got swap=%b num=%0d v0=%h drop=%0d exp 1 12 %h 1",
               swap_pulse, num_triangles, vertices_2d[0], mk_vert(5, 6), drop_count);
    end
  endtask

  task automatic test_reset_pending();
    do_commit(5);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstpend_pending got ready=%b exp=0", wr_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || num_triangles !== 4'd0 || vertices_2d[0] !== '0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL rstpend_cleared got ready=%b num=%0d v0=%h drop=%0d exp 1 0 0 0",
               wr_ready, num_triangles, vertices_2d[0], drop_count);
    end
    frame_pulse();
    checks++;
    if (swap_pulse !== 1'b0 || drop_count !== 8'd1 || num_triangles !== 4'd0) begin
      failures++;
      $display("FAIL rstpend_commit_discarded got swap=%b drop=%0d num=%0d exp 0 1 0",
               swap_pulse, drop_count, num_triangles);
    end
    do_commit(13);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL rstpend_clamp_err got=%b exp=1", err);
    end
    frame_pulse();
    checks++;
    if (swap_pulse !== 1'b1 || num_triangles !== 4'd12) begin
      failures++;
      $display("FAIL rstpend_clamp_swap got swap=%b num=%0d exp 1 12", swap_pulse, num_triangles);
    end
  endtask

  initial begin
    rst             = 1'b1;
    frame           = 1'b0;
    wr_valid        = 1'b0;
    wr_is_tri       = 1'b0;
    wr_index        = 4'd0;
    wr_vertex       = '0;
    wr_tri          = '0;
    commit          = 1'b0;
    commit_num_tris = 4'd0;

    test_reset();
    test_swap();
    test_drop();
    test_range();
    test_commit_frame_same();
    test_reset_pending();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
